// File: rtl/signed_mac_accum_pkg.sv
// Shared types and constants for the signed multiply-accumulate block.
package signed_mac_accum_pkg;

  // Guard bits added above the product width for the default accumulator.
  localparam int unsigned AccGuardBits = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/signed_acc_add.sv
// Combinational sign-extend, wrapping add, and signed-overflow detect.
module signed_acc_add #(
  parameter int unsigned P = 16,
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [P-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] b_ext;

  assign b_ext = W'($signed(b));
  assign sum   = a + b_ext;
  // Overflow only when both operands share a sign the result does not.
  assign ovf   = (a[W-1] == b_ext[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/signed_mac_accum.sv
// Accumulates LEN signed products into one result over valid/ready streams.
module signed_mac_accum
  import signed_mac_accum_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 8,
  parameter int unsigned ACC_W = N + M + AccGuardBits,
  parameter int unsigned LEN   = 16,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N+M-1:0]   prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LEN - 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               add_ovf;
  logic               beat;

  signed_acc_add #(
    .P (N + M),
    .W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (prod),
    .sum (acc_d),
    .ovf (add_ovf)
  );

  assign in_ready  = (state_q == StAccum);
  assign busy      = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign beat      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            ovf_q <= ovf_q | add_ovf;
            if (cnt_q == LastCnt) state_q <= StDone;
          end
        end
        StDone: begin
          // Result is held until the consumer takes it; start alone is ignored.
          if (out_ready) begin
            if (start) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              state_q <= StAccum;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mac_accum.sv
// Directed self-checking bench for signed_mac_accum over three parameter sets.
module tb_signed_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] prod = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        start4 = 1'b0, start16 = 1'b0, start2 = 1'b0;

  logic        in_ready4, out_valid4, ovf4, busy4;
  logic [23:0] acc4;
  logic        in_ready16, out_valid16, ovf16, busy16;
  logic [23:0] acc16;
  logic        in_ready2, out_valid2, ovf2, busy2;
  logic [15:0] acc2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  signed_mac_accum #(.N(8), .M(8), .LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready4), .acc_out(acc4), .ovf(ovf4), .out_valid(out_valid4),
    .out_ready(out_ready), .busy(busy4)
  );

  signed_mac_accum #(.N(8), .M(8), .LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready16), .acc_out(acc16), .ovf(ovf16), .out_valid(out_valid16),
    .out_ready(out_ready), .busy(busy16)
  );

  signed_mac_accum #(.N(8), .M(8), .ACC_W(16), .LEN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready2), .acc_out(acc2), .ovf(ovf2), .out_valid(out_valid2),
    .out_ready(out_ready), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat4(input logic [15:0] p);
    prod     = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_acc4", 32'(acc4), 32'h0);
    chk("rst_out_valid4", 32'(out_valid4), 32'h0);
    chk("rst_in_ready4", 32'(in_ready4), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);
    chk("rst_ovf4", 32'(ovf4), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: 3, -5, 7, -1 -> 4.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t1_in_ready", 32'(in_ready4), 32'h1);
    chk("t1_busy", 32'(busy4), 32'h1);
    beat4(16'd3);
    beat4(16'hFFFB);
    beat4(16'd7);
    chk("t1_no_early_valid", 32'(out_valid4), 32'h0);
    beat4(16'hFFFF);
    chk("t1_out_valid", 32'(out_valid4), 32'h1);
    chk("t1_acc", 32'(acc4), 32'h4);
    chk("t1_ovf", 32'(ovf4), 32'h0);
    chk("t1_in_ready_done", 32'(in_ready4), 32'h0);

    // Test 4: back-pressure with a start pulse; result must be held.
    out_ready = 1'b0;
    start4 = 1'b1;
    prod = 16'h1234;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) start4 = 1'b0;
      chk("t4_hold_valid", 32'(out_valid4), 32'h1);
      chk("t4_hold_acc", 32'(acc4), 32'h4);
      chk("t4_in_ready", 32'(in_ready4), 32'h0);
    end
    in_valid = 1'b0;
    start4 = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_valid", 32'(out_valid4), 32'h0);
    chk("t4_idle_busy", 32'(busy4), 32'h0);
    chk("t4_idle_in_ready", 32'(in_ready4), 32'h0);

    // Test 3: gapped input; skipped prods must not be summed.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    beat4(16'd10);
    prod = 16'd999; tick();
    prod = 16'd999; tick();
    beat4(16'd20);
    prod = 16'd999; tick();
    beat4(16'd30);
    chk("t3_no_early_valid", 32'(out_valid4), 32'h0);
    beat4(16'd40);
    chk("t3_out_valid", 32'(out_valid4), 32'h1);
    chk("t3_acc", 32'(acc4), 32'd100);

    // Test 5: handshake and start together restart without an idle cycle.
    out_ready = 1'b1;
    start4 = 1'b1;
    tick();
    out_ready = 1'b0;
    start4 = 1'b0;
    chk("t5_in_ready", 32'(in_ready4), 32'h1);
    chk("t5_acc", 32'(acc4), 32'h0);
    chk("t5_ovf", 32'(ovf4), 32'h0);
    chk("t5_out_valid", 32'(out_valid4), 32'h0);

    // Test 6: async reset mid-accumulation, then a fresh sum.
    beat4(16'd5);
    beat4(16'd6);
    chk("t6_partial", 32'(acc4), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid4), 32'h0);
    chk("t6_rst_in_ready", 32'(in_ready4), 32'h0);
    chk("t6_rst_acc", 32'(acc4), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_idle", 32'(busy4), 32'h0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    beat4(16'd1);
    beat4(16'd2);
    beat4(16'd3);
    beat4(16'd4);
    chk("t6_fresh_valid", 32'(out_valid4), 32'h1);
    chk("t6_fresh_acc", 32'(acc4), 32'd10);

    // Test 2a: LEN=16 of -32768 -> -524288 without overflow.
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2a_valid_low", 32'(out_valid16), 32'h0);
      beat4(16'h8000);
    end
    chk("t2a_valid", 32'(out_valid16), 32'h1);
    chk("t2a_acc", 32'(acc16), 32'hF80000);
    chk("t2a_ovf", 32'(ovf16), 32'h0);

    // Test 2b: ACC_W=16, 0x7FFF + 1 wraps to 0x8000 and flags overflow.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    beat4(16'h7FFF);
    chk("t2b_ovf_before", 32'(ovf2), 32'h0);
    beat4(16'h0001);
    chk("t2b_valid", 32'(out_valid2), 32'h1);
    chk("t2b_acc", 32'(acc2), 32'h8000);
    chk("t2b_ovf", 32'(ovf2), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2b_idle", 32'(out_valid2), 32'h0);
    chk("t2b_ovf_sticky", 32'(ovf2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
